dff_reg: RTL and testbench



---
 rtl/cpu_pkg.sv | 11 +
 rtl/dff_stage.sv | 24 ++
 rtl/dff_reg.sv | 41 ++++
 tb/tb_dff_reg.sv | 115 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants for register primitives.
package cpu_pkg;

    localparam int DATA_W     = 32;
    localparam int MAX_STAGES = 16;

    function automatic bit stages_legal(input int stages);
        return (stages >= 1) && (stages <= MAX_STAGES);
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One WIDTH-bit register with synchronous active-high reset to RESET_VALUE.
module dff_stage #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    assign data_d = d_i;

    always_ff @(posedge clk) begin
        if (reset) data_q <= RESET_VALUE;
        else       data_q <= data_d;
    end

    assign q_o = data_q;

endmodule

// File: rtl/dff_reg.sv
// Parameterizable D register / delay line: STAGES cascaded dff_stage instances.
module dff_reg
    import cpu_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (WIDTH < 1) begin : g_bad_width
        $error("dff_reg: WIDTH must be >= 1");
    end
    if (!stages_legal(STAGES)) begin : g_bad_stages
        $error("dff_reg: STAGES must be in 1..%0d", MAX_STAGES);
    end

    // chain[0] is the input; chain[i+1] is the output of stage i.
    logic [STAGES:0][WIDTH-1:0] chain;

    assign chain[0] = d;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        dff_stage #(
            .WIDTH      (WIDTH),
            .RESET_VALUE(RESET_VALUE)
        ) u_stage (
            .clk  (clk),
            .reset(reset),
            .d_i  (chain[i]),
            .q_o  (chain[i+1])
        );
    end

    assign q = chain[STAGES];

endmodule

// File: tb/tb_dff_reg.sv
// Random + directed check of three dff_reg configurations against an edge-history model.
module tb_dff_reg;

    localparam int NMAX = 1024;

    logic       clk = 1'b0;
    logic       reset;
    logic       d0;
    logic [7:0] d1;
    logic [3:0] d2;
    logic       q0;
    logic [7:0] q1;
    logic [3:0] q2;

    int vectors = 0;
    int errs    = 0;
    int n       = 0;

    logic [7:0] dh [3][NMAX];
    bit         rh [NMAX];

    always #10 clk = ~clk;

    dff_reg u_dut0 (.clk(clk), .reset(reset), .d(d0), .q(q0));

    dff_reg #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'hA5)) u_dut1 (
        .clk(clk), .reset(reset), .d(d1), .q(q1));

    dff_reg #(.WIDTH(4), .STAGES(2), .RESET_VALUE(4'h0)) u_dut2 (
        .clk(clk), .reset(reset), .d(d2), .q(q2));

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, n);
        end
    endtask

    // q after edge e is the d sampled S-1 edges earlier, unless a reset hit any edge
    // in that window (which wipes every stage). Edges before time zero count as reset.
    function automatic logic [7:0] model(input int which, input int e, input int s,
                                         input logic [7:0] rv);
        for (int k = e - s + 1; k <= e; k++) begin
            if (k < 0 || rh[k]) return rv;
        end
        return dh[which][e - s + 1];
    endfunction

    // One edge: drive at negedge, sample after posedge, glitch inputs mid-cycle.
    task automatic cyc(input logic r, input logic v0, input logic [7:0] v1, input logic [3:0] v2);
        logic [7:0] s0, s1, s2;
        @(negedge clk);
        reset = r; d0 = v0; d1 = v1; d2 = v2;
        @(posedge clk);
        rh[n] = r; dh[0][n] = {7'b0, v0}; dh[1][n] = v1; dh[2][n] = {4'b0, v2};
        #1;
        chk("q0", {7'b0, q0}, model(0, n, 1, 8'h00));
        chk("q1", q1,         model(1, n, 3, 8'hA5));
        chk("q2", {4'b0, q2}, model(2, n, 2, 8'h00));
        s0 = {7'b0, q0}; s1 = q1; s2 = {4'b0, q2};
        #4;
        reset = $urandom_range(0, 1); d0 = $urandom_range(0, 1);
        d1 = 8'($urandom); d2 = 4'($urandom);
        #2;
        chk("q0_hold", {7'b0, q0}, s0);
        chk("q1_hold", q1, s1);
        chk("q2_hold", {4'b0, q2}, s2);
        n++;
    endtask

    initial begin
        reset = 1'b1; d0 = 1'b0; d1 = 8'h00; d2 = 4'h0;

        // reset, then reset priority over d=1
        cyc(1'b1, 1'b0, 8'h00, 4'h0);
        chk("rst_q0", {7'b0, q0}, 8'h00);
        chk("rst_q1", q1, 8'hA5);
        cyc(1'b1, 1'b1, 8'hFF, 4'hF);
        chk("rst_prio_q0", {7'b0, q0}, 8'h00);

        // data capture and 3-stage latency
        cyc(1'b0, 1'b1, 8'h3C, 4'hF);
        chk("d1_q0", {7'b0, q0}, 8'h01);
        chk("lat_q1_e0", q1, 8'hA5);
        cyc(1'b0, 1'b0, 8'h00, 4'h0);
        chk("d0_q0", {7'b0, q0}, 8'h00);
        chk("lat_q1_e1", q1, 8'hA5);
        chk("s2_F", {4'b0, q2}, 8'h0F);
        cyc(1'b0, 1'b1, 8'h11, 4'h5);
        chk("lat_q1_e2", q1, 8'h3C);
        chk("s2_0", {4'b0, q2}, 8'h00);

        // reset mid-stream discards in-flight data for S edges
        cyc(1'b1, 1'b1, 8'h77, 4'hA);
        chk("mid_rst_q1", q1, 8'hA5);
        chk("mid_rst_q0", {7'b0, q0}, 8'h00);
        cyc(1'b0, 1'b1, 8'h12, 4'h3);
        chk("mid_rst_q1_a", q1, 8'hA5);
        chk("rel_q0", {7'b0, q0}, 8'h01);
        cyc(1'b0, 1'b0, 8'h34, 4'hC);
        chk("mid_rst_q1_b", q1, 8'hA5);
        cyc(1'b0, 1'b0, 8'h56, 4'h9);
        chk("after_rst_q1", q1, 8'h12);

        // randomized stream with occasional reset
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) == 0), 1'($urandom), 8'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
